// File: rtl/rtc_lectura_bus.sv
// Periodic 11-register read of the RTC multiplexed bus with atomic commit to datos0..datos10.
// Optional BCD validation of each byte (frame dropped on error) under `RTC_LECTURA_BCD_CHECK_EN.
module rtc_lectura_bus #(
  parameter int T_FASE  = 10,
  parameter int PERIODO = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pausa,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic       ocupado,
  output logic       listo,
`ifdef RTC_LECTURA_BCD_CHECK_EN
  output logic       error_bcd,
`endif
  output logic [7:0] datos0,
  output logic [7:0] datos1,
  output logic [7:0] datos2,
  output logic [7:0] datos3,
  output logic [7:0] datos4,
  output logic [7:0] datos5,
  output logic [7:0] datos6,
  output logic [7:0] datos7,
  output logic [7:0] datos8,
  output logic [7:0] datos9,
  output logic [7:0] datos10
);
  localparam int FW = (T_FASE > 1) ? $clog2(T_FASE) : 1;
  localparam int PW = $clog2(PERIODO);
  localparam logic [FW-1:0] FASE_ULT = FW'(T_FASE - 1);
  localparam logic [PW-1:0] PER_ULT  = PW'(PERIODO - 1);
  localparam logic [3:0]    IDX_ULT  = 4'd10;

  typedef enum logic [2:0] {IDLE, DIR, ESP1, LEER, ESP2, COMMIT} estado_t;

  function automatic logic [7:0] dir_tabla(input logic [3:0] i);
    case (i)
      4'd0:    dir_tabla = 8'h21;
      4'd1:    dir_tabla = 8'h22;
      4'd2:    dir_tabla = 8'h23;
      4'd3:    dir_tabla = 8'h24;
      4'd4:    dir_tabla = 8'h25;
      4'd5:    dir_tabla = 8'h26;
      4'd6:    dir_tabla = 8'h27;
      4'd7:    dir_tabla = 8'h28;
      4'd8:    dir_tabla = 8'h41;
      4'd9:    dir_tabla = 8'h42;
      4'd10:   dir_tabla = 8'h43;
      default: dir_tabla = 8'h00;
    endcase
  endfunction

  estado_t          estado_q, estado_d;
  logic [FW-1:0]    fase_q, fase_d;
  logic [3:0]       idx_q, idx_d;
  logic [PW-1:0]    per_q;
  logic             pend_q;
  logic             toma, ultimo, captura, entra_commit, commit_ok;
  logic [10:0][7:0] shadow_q, datos_q;
  logic [7:0]       ad_out_q;
  logic             ad_oe_q, cs_n_q, rd_n_q, wr_n_q, a_d_q, ocupado_q, listo_q;

  always_comb begin
    estado_d = estado_q;
    fase_d   = fase_q;
    idx_d    = idx_q;
    toma     = 1'b0;
    ultimo   = (fase_q == FASE_ULT);
    case (estado_q)
      IDLE: if (pend_q && !pausa) begin
        toma     = 1'b1;
        idx_d    = '0;
        fase_d   = '0;
        estado_d = DIR;
      end
      DIR, ESP1, LEER: begin
        fase_d = ultimo ? '0 : fase_q + 1'b1;
        if (ultimo) estado_d = (estado_q == DIR) ? ESP1 : (estado_q == ESP1) ? LEER : ESP2;
      end
      ESP2: begin
        fase_d = ultimo ? '0 : fase_q + 1'b1;
        if (ultimo) begin
          if (idx_q < IDX_ULT) begin
            idx_d    = idx_q + 1'b1;
            estado_d = DIR;
          end else begin
            estado_d = COMMIT;
          end
        end
      end
      COMMIT:  estado_d = IDLE;
      default: estado_d = IDLE;
    endcase
  end

  assign captura      = (estado_q == LEER) && ultimo;
  assign entra_commit = (estado_d == COMMIT);

`ifdef RTC_LECTURA_BCD_CHECK_EN
  logic bcd_mal_q, byte_mal, error_bcd_q;
  assign byte_mal  = (ad_in[7:4] > 4'd9) || (ad_in[3:0] > 4'd9);
  assign commit_ok = !bcd_mal_q;
  assign error_bcd = error_bcd_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      bcd_mal_q   <= 1'b0;
      error_bcd_q <= 1'b0;
    end else begin
      if (estado_q == IDLE)        bcd_mal_q <= 1'b0;
      else if (captura && byte_mal) bcd_mal_q <= 1'b1;
      error_bcd_q <= entra_commit && bcd_mal_q;
    end
  end
`else
  assign commit_ok = 1'b1;
`endif

  // Outputs are registered from the next state so they line up with estado_q and never glitch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      estado_q  <= IDLE;
      fase_q    <= '0;
      idx_q     <= '0;
      per_q     <= '0;
      pend_q    <= 1'b0;
      shadow_q  <= '0;
      datos_q   <= '0;
      ad_out_q  <= '0;
      ad_oe_q   <= 1'b0;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      a_d_q     <= 1'b1;
      ocupado_q <= 1'b0;
      listo_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      fase_q   <= fase_d;
      idx_q    <= idx_d;
      per_q    <= (per_q == PER_ULT) ? '0 : per_q + 1'b1;
      // A wrap landing on the same edge as a frame start re-arms the trigger.
      if (toma)              pend_q <= 1'b0;
      if (per_q == PER_ULT)  pend_q <= 1'b1;
      for (int i = 0; i < 11; i++)
        if (captura && idx_q == 4'(i)) shadow_q[i] <= ad_in;
      if (entra_commit && commit_ok) datos_q <= shadow_q;
      ad_out_q  <= (estado_d == DIR) ? dir_tabla(idx_d) : 8'h00;
      ad_oe_q   <= (estado_d == DIR);
      cs_n_q    <= !((estado_d == DIR) || (estado_d == LEER));
      wr_n_q    <= (estado_d != DIR);
      rd_n_q    <= (estado_d != LEER);
      a_d_q     <= (estado_d != DIR);
      ocupado_q <= (estado_d != IDLE);
      listo_q   <= entra_commit && commit_ok;
    end
  end

  assign ad_out  = ad_out_q;
  assign ad_oe   = ad_oe_q;
  assign cs_n    = cs_n_q;
  assign rd_n    = rd_n_q;
  assign wr_n    = wr_n_q;
  assign a_d     = a_d_q;
  assign ocupado = ocupado_q;
  assign listo   = listo_q;
  assign datos0  = datos_q[0];
  assign datos1  = datos_q[1];
  assign datos2  = datos_q[2];
  assign datos3  = datos_q[3];
  assign datos4  = datos_q[4];
  assign datos5  = datos_q[5];
  assign datos6  = datos_q[6];
  assign datos7  = datos_q[7];
  assign datos8  = datos_q[8];
  assign datos9  = datos_q[9];
  assign datos10 = datos_q[10];
endmodule

// File: doc/rtc_lectura_bus.md
Name: rtc_lectura_bus

Overview:
- Upstream stage of the VGA display interface. Periodically reads 11 time, date and timer registers from the external RTC over its multiplexed address/data bus.
- Each register is captured into a shadow buffer. All 11 bytes are committed to the datos0..datos10 outputs in a single cycle, so the display never shows a torn frame.
- Reads are suspended while the user is programming the clock or chrono.

Parameters:
- T_FASE, 10, clocks per bus phase (100 ns at 100 MHz); legal range ≥2.
- PERIODO, 1_000_000, clocks between frame triggers (10 ms); must exceed 44*T_FASE+2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- pausa  in  1  1 = do not start new frames (programming mode)
- ad_in  in  8  RTC bus value read back from the tristate pad
- ad_out  out  8  value driven onto the RTC bus
- ad_oe  out  1  1 = pad drives ad_out
- cs_n  out  1  RTC chip select, active low
- rd_n  out  1  RTC read strobe, active low
- wr_n  out  1  RTC write strobe, active low
- a_d  out  1  0 = address phase, 1 = data phase
- ocupado  out  1  high while a frame is in progress
- listo  out  1  one-clock pulse on commit
- datos0..datos10  out  8 each  committed BCD bytes: sec, min, hour, date, month, year, weekday, week number, timer sec, timer min, timer hour

Behaviour:
- Reset (reset=0 at a clk edge) forces all of the following on that edge, regardless of state:
  - cs_n=rd_n=wr_n=a_d=1, ad_oe=0, ad_out=0
  - ocupado=0, listo=0
  - datos*=0 and shadow buffer=0
  - FSM=IDLE, phase counter=0, period counter=0, pending trigger=0
- Period counter:
  - Counts 0..PERIODO-1 and wraps; counts regardless of FSM state.
  - On wrap it sets pending=1.
  - Wrap while pending is already 1 is absorbed (no queue).
- Address table, index 0..10: 21h, 22h, 23h, 24h, 25h, 26h, 27h, 28h, 41h, 42h, 43h.
- FSM states: IDLE, DIR, ESP1, LEER, ESP2, COMMIT. Each timed state lasts exactly T_FASE clocks.
  - IDLE: all strobes high, ad_oe=0. If pending=1 and pausa=0: clear pending, idx=0, go to DIR, ocupado=1 from the next cycle. If pausa=1, pending is held.
  - DIR: cs_n=0, a_d=0, wr_n=0, ad_oe=1, ad_out=table[idx].
  - ESP1: cs_n=wr_n=1, ad_oe=0.
  - LEER: cs_n=0, a_d=1, rd_n=0, ad_oe=0. ad_in is registered into shadow[idx] on the last LEER cycle.
  - ESP2: strobes high. At the end, if idx<10 then idx+1 and go to DIR; else go to COMMIT.
  - COMMIT (one cycle): datos0..10 <= shadow, listo=1 for this cycle only, ocupado=0 on exit, go to IDLE.
- All bus outputs are registered and glitch-free. ad_oe never overlaps rd_n=0.
- Frame length: IDLE→COMMIT is 44*T_FASE+1 clocks.
- pausa is sampled only in IDLE. A frame already in progress completes and commits.
- datos* change only in COMMIT (or on reset) and hold their value otherwise.

Optional Feature:
- Macro RTC_LECTURA_BCD_CHECK_EN.
- When defined:
  - Each byte is checked when registered in LEER: both nibbles must be ≤9.
  - A sticky frame-invalid flag is kept for the frame.
  - In COMMIT, if the flag is set, datos* keep their old values, listo stays 0, and an extra output error_bcd pulses for one clock. The flag clears in IDLE.
- When undefined: no check; error_bcd port is absent; commit is unconditional.

Test Plan:
- Reset: T_FASE=4, PERIODO=400, hold reset=0 for 3 clks mid-LEER → next edge has all strobes=1, ad_oe=0, datos*=00h, ocupado=0; first frame starts 400 clks after release.
- Full frame: RTC model returns 59h,34h,12h,31h,12h,17h,06h,52h,30h,15h,01h → listo pulses once at clk 177 of the frame; datos0=59h … datos10=01h; 11 address phases show ad_out=21h..28h,41h..43h.
- Bus timing: check each DIR and LEER low pulse is exactly 4 clks; cs_n high ≥4 clks between phases; ad_oe=0 whenever rd_n=0.
- Atomicity: change the model's seconds register mid-frame → datos* unchanged until the single commit cycle, then all update together.
- Pausa: assert pausa before a wrap, hold for 3 periods → no frame runs; on release, exactly one frame starts immediately (pending held); pausa raised mid-frame → that frame still commits.
- BCD check (macro on): model returns 5Ah for minutes → error_bcd pulses, listo=0, datos* retain the previous frame's values.
